pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 10, sets the instruction-memory word-address width of every PC port.
REQ-002 Parameter RESET_PC, default 0, sets the PC value loaded on reset.
REQ-003 Parameter STEP, default 1, sets the sequential increment in words.
REQ-004 Parameter RAS_DEPTH, default 4 (legal 2..16), sets the return-address-stack entry count.
REQ-005 Port clk, input, 1, the single clock; all state updates on posedge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port en, input, 1, global enable; when low, all state holds.
REQ-008 Port stall, input, 1, hold the PC (pipeline bubble).
REQ-009 Port load_pc, input, 1, redirect from execute (branch/jump resolved).
REQ-010 Port pc_new, input, ADDR_W, redirect target.
REQ-011 Port call, input, 1, fetched instruction is a call; push ret_addr.
REQ-012 Port ret_addr, input, ADDR_W, link address to push.
REQ-013 Port ret, input, 1, fetched instruction is a return; pop and predict.
REQ-014 Port ras_flush, input, 1, discard all RAS entries.
REQ-015 Port pc, output, ADDR_W, current fetch address (registered).
REQ-016 Port pc_4, output, ADDR_W, combinational pc + STEP, modulo 2^ADDR_W.
REQ-017 Port pred_taken, output, 1, registered; high for one cycle when pc was loaded from the RAS.
REQ-018 Port ras_count, output, $clog2(RAS_DEPTH+1), number of valid entries.
REQ-019 Port ras_empty / ras_full, outputs, 1 each, count==0 / count==RAS_DEPTH.
REQ-020 Port ras_ovf / ras_unf, outputs, 1 each, registered one-cycle pulses for push-when-full and pop-when-empty.

Function
REQ-021 "Accept" SHALL mean en=1, load_pc=0 and stall=0; call and ret take effect only on an accepted cycle.
REQ-022 When en=1, the PC SHALL update with this priority: load_pc -> pc_new; else stall -> hold; else accepted ret with count>0 -> RAS top; else pc_4.
REQ-023 Arithmetic SHALL wrap: the PC value 2^ADDR_W - STEP followed by a sequential step yields 0, with no flag.
REQ-024 A push SHALL write ret_addr at the top, and count SHALL increment, saturating at RAS_DEPTH.
REQ-025 A push when full SHALL overwrite the oldest entry as a circular buffer; count SHALL stay at RAS_DEPTH and ras_ovf SHALL pulse on the next cycle.
REQ-026 A pop with count>0 SHALL return the top entry and decrement count; pred_taken SHALL go high on the next cycle.
REQ-027 A pop with count==0 SHALL leave the RAS unchanged, pulse ras_unf, and let the PC follow the sequential path.
REQ-028 Simultaneous call and ret on an accepted cycle SHALL redirect the PC to the old top, replace the top with ret_addr, and leave count unchanged; with count==0 they SHALL act as a push plus ras_unf.
REQ-029 ras_flush SHALL set count to 0 synchronously, take priority over call and ret, and apply even when en=0.
REQ-030 When load_pc=1 or stall=1, call and ret SHALL be ignored: no pop, no push, no pulse.
REQ-031 pred_taken, ras_ovf and ras_unf SHALL be low on any cycle that does not follow their trigger.

Reset
REQ-032 On rst_n low, asynchronously: pc = RESET_PC, count = 0, and pred_taken, ras_ovf and ras_unf = 0; stack contents are cleared to 0.
REQ-033 Reset asserted mid-operation SHALL discard all RAS state; the first posedge after release SHALL produce the sequential PC RESET_PC+STEP, if accepted.

Verification
REQ-034 Reset with RESET_PC=0x100, then 3 accepted cycles -> pc: 0x100, 0x101, 0x102, 0x103; pc_4 = pc+1.
REQ-035 pc=0x3FF, sequential step -> pc=0x000; stall=1 -> pc holds; en=0 with load_pc=1 -> pc holds.
REQ-036 call with ret_addr=0x050, then call with 0x060, then ret, then ret -> pc 0x060 then 0x050, pred_taken pulses twice, count 2->1->0, ras_empty=1.
REQ-037 Five pushes 0x1..0x5 into RAS_DEPTH=4 -> ras_ovf pulses once, count=4; four pops -> 0x5, 0x4, 0x3, 0x2; a fifth pop -> ras_unf pulses and pc takes the sequential value.
REQ-038 load_pc=1 with pc_new=0x200 together with ret, count=2 -> pc=0x200, count stays 2, pred_taken=0.
REQ-039 count=2, ras_flush together with call -> count=0, no push; call and ret together with top 0x070 and ret_addr 0x080 -> pc=0x070, new top 0x080, count unchanged.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch program-counter generator with a circular return-address stack.
// Produces the next fetch address from redirects, stalls, RAS predictions or sequential stepping.
module pc_gen #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic                                 stall,
  input  logic                                 load_pc,
  input  logic [ADDR_W-1:0]                    pc_new,
  input  logic                                 call,
  input  logic [ADDR_W-1:0]                    ret_addr,
  input  logic                                 ret,
  input  logic                                 ras_flush,
  output logic [ADDR_W-1:0]                    pc,
  output logic [ADDR_W-1:0]                    pc_4,
  output logic                                 pred_taken,
  output logic [$clog2(RAS_DEPTH+1)-1:0]       ras_count,
  output logic                                 ras_empty,
  output logic                                 ras_full,
  output logic                                 ras_ovf,
  output logic                                 ras_unf
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic              pred_q, pred_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];

  logic              accept;
  logic              do_push;
  logic              do_pop;
  logic              pop_hit;
  logic              is_full;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  top_inc;
  logic [PTR_W-1:0]  top_dec;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] ras_top;

  assign seq_pc  = pc_q + ADDR_W'(STEP);
  assign ras_top = mem_q[top_q];
  assign is_full = (cnt_q == CNT_W'(RAS_DEPTH));

  // Circular pointer arithmetic that also works for non-power-of-two depths.
  assign top_inc = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
  assign top_dec = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);

  // Call/return only act on accepted cycles, and a flush overrides them.
  assign accept  = en & ~load_pc & ~stall;
  assign do_push = accept & call & ~ras_flush;
  assign do_pop  = accept & ret & ~ras_flush;
  assign pop_hit = do_pop & (cnt_q != '0);

  // Next-state for PC, stack bookkeeping and the one-cycle status pulses.
  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    top_d  = top_q;
    pred_d = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    wr_en  = 1'b0;
    wr_idx = top_q;

    if (en) begin
      if (load_pc) begin
        pc_d = pc_new;
      end else if (!stall) begin
        pc_d = pop_hit ? ras_top : seq_pc;
      end
    end

    if (ras_flush) begin
      cnt_d = '0;
    end else if (do_push && pop_hit) begin
      // Call and return together: predict the old top, then replace it in place.
      wr_en  = 1'b1;
      wr_idx = top_q;
      pred_d = 1'b1;
    end else if (do_push) begin
      wr_en  = 1'b1;
      wr_idx = top_inc;
      top_d  = top_inc;
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_hit) begin
      top_d  = top_dec;
      cnt_d  = cnt_q - CNT_W'(1);
      pred_d = 1'b1;
    end

    if (do_pop && !pop_hit) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= ADDR_W'(RESET_PC);
      cnt_q  <= '0;
      top_q  <= '0;
      pred_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      top_q  <= top_d;
      pred_q <= pred_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Stack storage; overwriting the slot after the top retires the oldest entry when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[wr_idx] <= ret_addr;
    end
  end

  assign pc         = pc_q;
  assign pc_4       = seq_pc;
  assign pred_taken = pred_q;
  assign ras_count  = cnt_q;
  assign ras_empty  = (cnt_q == '0);
  assign ras_full   = is_full;
  assign ras_ovf    = ovf_q;
  assign ras_unf    = unf_q;

endmodule
